ccx_ext_arb: RTL and testbench

Two-requester arbiter sharing the core complex external memory port between core instruction-fetch and data-access traffic. It sits between the interconnect's external-bound instruction and data paths and the `emem_*` port. Only one requester drives the external port at a time. A presented request stays locked until granted. Read data and error responses are steered back to the requester that owns them, and a streak counter bounds instruction-fetch starvation under data priority.

---
 rtl/ccx_pkg.sv | 18 +
 rtl/ccx_ext_arb.sv | 139 +++++++++++++
 tb/tb_ccx_ext_arb.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ccx_pkg.sv
// Shared types and widths for the core complex external memory path.
package ccx_pkg;

    localparam int unsigned CCX_AW = 39;
    localparam int unsigned CCX_DW = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } ccx_arb_state_t;

    typedef enum logic {
        SEL_I = 1'b0,
        SEL_D = 1'b1
    } ccx_arb_sel_t;

endpackage

// File: rtl/ccx_ext_arb.sv
// Instruction/data arbiter for the shared external memory port, with
// request locking, response owner steering and a data-streak starvation bound.
module ccx_ext_arb
    import ccx_pkg::*;
#(
    parameter int unsigned AW          = CCX_AW,
    parameter int unsigned DW          = CCX_DW,
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic            g_clk,
    input  logic            g_resetn,

    input  logic            imem_req,
    input  logic [AW-1:0]   imem_addr,
    input  logic            imem_wen,
    input  logic [DW/8-1:0] imem_strb,
    input  logic [DW-1:0]   imem_wdata,
    output logic            imem_gnt,
    output logic            imem_err,
    output logic [DW-1:0]   imem_rdata,

    input  logic            dmem_req,
    input  logic [AW-1:0]   dmem_addr,
    input  logic            dmem_wen,
    input  logic [DW/8-1:0] dmem_strb,
    input  logic [DW-1:0]   dmem_wdata,
    output logic            dmem_gnt,
    output logic            dmem_err,
    output logic [DW-1:0]   dmem_rdata,

    output logic            emem_req,
    output logic [AW-1:0]   emem_addr,
    output logic            emem_wen,
    output logic [DW/8-1:0] emem_strb,
    output logic [DW-1:0]   emem_wdata,
    input  logic            emem_gnt,
    input  logic            emem_err,
    input  logic [DW-1:0]   emem_rdata
);

    localparam int unsigned SW       = DW / 8;
    localparam int unsigned STREAK_W = 4;
    localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_DSTREAK);

    ccx_arb_state_t        state_q, state_d;
    ccx_arb_sel_t          rsp_sel_q, rsp_sel_d;
    logic                  rsp_v_q, rsp_v_d;
    logic [STREAK_W-1:0]   dstreak_q, dstreak_d;

    ccx_arb_sel_t          sel;
    logic                  fwd_req;
    logic                  accept;

    // Selection: fixed while locked, otherwise data-first unless the streak limit is hit.
    always_comb begin
        sel = SEL_D;
        case (state_q)
            LOCK_I:  sel = SEL_I;
            LOCK_D:  sel = SEL_D;
            default: begin
                if (imem_req && !dmem_req) begin
                    sel = SEL_I;
                end else if (imem_req && dmem_req && (dstreak_q == MAX_STREAK)) begin
                    sel = SEL_I;
                end
            end
        endcase
        fwd_req = (sel == SEL_I) ? imem_req : dmem_req;
        accept  = g_resetn & fwd_req & emem_gnt;
    end

    // Next state, response owner and streak counter updates.
    always_comb begin
        state_d   = IDLE;
        rsp_v_d   = accept;
        rsp_sel_d = rsp_sel_q;
        dstreak_d = dstreak_q;

        if (fwd_req && !emem_gnt) begin
            state_d = (sel == SEL_I) ? LOCK_I : LOCK_D;
        end

        if (accept) begin
            rsp_sel_d = sel;
        end

        if (!imem_req || (accept && (sel == SEL_I))) begin
            dstreak_d = '0;
        end else if (accept && (sel == SEL_D) && (dstreak_q != MAX_STREAK)) begin
            dstreak_d = dstreak_q + STREAK_W'(1);
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q   <= IDLE;
            rsp_v_q   <= 1'b0;
            rsp_sel_q <= SEL_I;
            dstreak_q <= '0;
        end else begin
            state_q   <= state_d;
            rsp_v_q   <= rsp_v_d;
            rsp_sel_q <= rsp_sel_d;
            dstreak_q <= dstreak_d;
        end
    end

    // External port mux and grant/error steering; all forced low while in reset.
    always_comb begin
        emem_req   = 1'b0;
        emem_addr  = '0;
        emem_wen   = 1'b0;
        emem_strb  = '0;
        emem_wdata = '0;
        if (g_resetn) begin
            emem_req = fwd_req;
            if (sel == SEL_I) begin
                emem_addr  = imem_addr;
                emem_wen   = imem_wen;
                emem_strb  = SW'(imem_strb);
                emem_wdata = imem_wdata;
            end else begin
                emem_addr  = dmem_addr;
                emem_wen   = dmem_wen;
                emem_strb  = SW'(dmem_strb);
                emem_wdata = dmem_wdata;
            end
        end

        imem_gnt = g_resetn & emem_gnt & (sel == SEL_I) & imem_req;
        dmem_gnt = g_resetn & emem_gnt & (sel == SEL_D) & dmem_req;
        imem_err = g_resetn & emem_err & rsp_v_q & (rsp_sel_q == SEL_I);
        dmem_err = g_resetn & emem_err & rsp_v_q & (rsp_sel_q == SEL_D);
    end

    assign imem_rdata = emem_rdata;
    assign dmem_rdata = emem_rdata;

endmodule

// File: tb/tb_ccx_ext_arb.sv
// Directed self-checking bench for ccx_ext_arb.
module tb_ccx_ext_arb;

    localparam int unsigned AW = 39;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = DW / 8;

    localparam logic [AW-1:0] A_I0 = 39'h0010000040;
    localparam logic [AW-1:0] A_I  = 39'h0010000100;
    localparam logic [AW-1:0] A_D  = 39'h0020000200;

    logic            g_clk = 1'b0;
    logic            g_resetn;
    logic            imem_req, imem_wen, imem_gnt, imem_err;
    logic [AW-1:0]   imem_addr;
    logic [SW-1:0]   imem_strb;
    logic [DW-1:0]   imem_wdata, imem_rdata;
    logic            dmem_req, dmem_wen, dmem_gnt, dmem_err;
    logic [AW-1:0]   dmem_addr;
    logic [SW-1:0]   dmem_strb;
    logic [DW-1:0]   dmem_wdata, dmem_rdata;
    logic            emem_req, emem_wen, emem_gnt, emem_err;
    logic [AW-1:0]   emem_addr;
    logic [SW-1:0]   emem_strb;
    logic [DW-1:0]   emem_wdata, emem_rdata;

    int tests = 0;
    int fails = 0;

    ccx_ext_arb #(.AW(AW), .DW(DW), .MAX_DSTREAK(4)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_wen(imem_wen),
        .imem_strb(imem_strb), .imem_wdata(imem_wdata),
        .imem_gnt(imem_gnt), .imem_err(imem_err), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
        .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
        .emem_req(emem_req), .emem_addr(emem_addr), .emem_wen(emem_wen),
        .emem_strb(emem_strb), .emem_wdata(emem_wdata),
        .emem_gnt(emem_gnt), .emem_err(emem_err), .emem_rdata(emem_rdata)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    initial begin
        g_resetn   = 1'b0;
        imem_req   = 1'b1; imem_addr = A_I0; imem_wen = 1'b0;
        imem_strb  = 8'hFF; imem_wdata = 64'h1111_2222_3333_4444;
        dmem_req   = 1'b1; dmem_addr = A_D; dmem_wen = 1'b1;
        dmem_strb  = 8'h0F; dmem_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
        emem_gnt   = 1'b1; emem_err = 1'b1; emem_rdata = 64'hDEAD_BEEF_0000_0001;

        // Outputs forced low under reset even with live inputs
        #3;
        chk("rst_emem_req", 64'(emem_req), 64'd0);
        chk("rst_emem_addr", 64'(emem_addr), 64'd0);
        chk("rst_emem_wdata", emem_wdata, 64'd0);
        chk("rst_imem_gnt", 64'(imem_gnt), 64'd0);
        chk("rst_dmem_gnt", 64'(dmem_gnt), 64'd0);
        chk("rst_imem_err", 64'(imem_err), 64'd0);
        chk("rst_dmem_err", 64'(dmem_err), 64'd0);

        imem_req = 1'b0; dmem_req = 1'b0; emem_gnt = 1'b0; emem_err = 1'b0;
        tick();
        g_resetn = 1'b1;

        // Single instruction fetch, then error response routed to imem
        tick();
        imem_req = 1'b1; imem_addr = A_I0; emem_gnt = 1'b1;
        #1;
        chk("t1_emem_req", 64'(emem_req), 64'd1);
        chk("t1_emem_addr", 64'(emem_addr), 64'(A_I0));
        chk("t1_emem_wdata", emem_wdata, 64'h1111_2222_3333_4444);
        chk("t1_emem_strb", 64'(emem_strb), 64'hFF);
        chk("t1_imem_gnt", 64'(imem_gnt), 64'd1);
        chk("t1_dmem_gnt", 64'(dmem_gnt), 64'd0);
        tick();
        imem_req = 1'b0; emem_err = 1'b1; emem_rdata = 64'h0123_4567_89AB_CDEF;
        #1;
        chk("t1_imem_err", 64'(imem_err), 64'd1);
        chk("t1_dmem_err", 64'(dmem_err), 64'd0);
        chk("t1_imem_rdata", imem_rdata, 64'h0123_4567_89AB_CDEF);
        chk("t1_dmem_rdata", dmem_rdata, 64'h0123_4567_89AB_CDEF);
        chk("t1_idle_req", 64'(emem_req), 64'd0);
        tick();
        emem_err = 1'b0;
        #1;
        chk("t1_err_once", 64'(imem_err), 64'd0);

        // Data streak: four data grants, then one instruction grant, then data again
        imem_req = 1'b1; imem_addr = A_I; dmem_req = 1'b1; dmem_addr = A_D; emem_gnt = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (k == 4) begin
                chk($sformatf("t2_igrant%0d", k), 64'(imem_gnt), 64'd1);
                chk($sformatf("t2_dgrant%0d", k), 64'(dmem_gnt), 64'd0);
                chk($sformatf("t2_addr%0d", k), 64'(emem_addr), 64'(A_I));
            end else begin
                chk($sformatf("t2_igrant%0d", k), 64'(imem_gnt), 64'd0);
                chk($sformatf("t2_dgrant%0d", k), 64'(dmem_gnt), 64'd1);
                chk($sformatf("t2_addr%0d", k), 64'(emem_addr), 64'(A_D));
            end
            tick();
        end
        imem_req = 1'b0; dmem_req = 1'b0; emem_gnt = 1'b0;
        tick();

        // Instruction lock holds against a later data request
        imem_req = 1'b1; imem_addr = A_I;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t3_lock_addr%0d", k), 64'(emem_addr), 64'(A_I));
            chk($sformatf("t3_lock_ignt%0d", k), 64'(imem_gnt), 64'd0);
            tick();
        end
        dmem_req = 1'b1; dmem_addr = A_D;
        #1;
        chk("t3_keep_addr", 64'(emem_addr), 64'(A_I));
        chk("t3_keep_req", 64'(emem_req), 64'd1);
        chk("t3_no_dgnt", 64'(dmem_gnt), 64'd0);
        tick();
        emem_gnt = 1'b1;
        #1;
        chk("t3_igrant", 64'(imem_gnt), 64'd1);
        chk("t3_dgnt_held", 64'(dmem_gnt), 64'd0);
        chk("t3_grant_addr", 64'(emem_addr), 64'(A_I));
        tick();
        imem_req = 1'b0;
        #1;
        chk("t3_dgrant_next", 64'(dmem_gnt), 64'd1);
        chk("t3_daddr_next", 64'(emem_addr), 64'(A_D));
        tick();
        dmem_req = 1'b0; emem_gnt = 1'b0;
        tick();

        // Locked data request withdrawn: one idle cycle, then waiting imem forwarded
        dmem_req = 1'b1;
        #1;
        chk("t4_dlock_req", 64'(emem_req), 64'd1);
        chk("t4_dlock_gnt", 64'(dmem_gnt), 64'd0);
        tick();
        imem_req = 1'b1;
        #1;
        chk("t4_dlock_addr", 64'(emem_addr), 64'(A_D));
        chk("t4_dlock_ignt", 64'(imem_gnt), 64'd0);
        tick();
        dmem_req = 1'b0; emem_gnt = 1'b1;
        #1;
        chk("t4_drop_req", 64'(emem_req), 64'd0);
        chk("t4_drop_ignt", 64'(imem_gnt), 64'd0);
        tick();
        #1;
        chk("t4_fwd_req", 64'(emem_req), 64'd1);
        chk("t4_fwd_addr", 64'(emem_addr), 64'(A_I));
        chk("t4_fwd_ignt", 64'(imem_gnt), 64'd1);
        tick();
        imem_req = 1'b0; emem_gnt = 1'b0;
        tick();

        // Async reset right after a data acceptance drops the pending response
        dmem_req = 1'b1; emem_gnt = 1'b1;
        #1;
        chk("t5_dgrant", 64'(dmem_gnt), 64'd1);
        tick();
        dmem_req = 1'b0; emem_gnt = 1'b0;
        #2;
        g_resetn = 1'b0; imem_req = 1'b1; dmem_req = 1'b1; emem_gnt = 1'b1; emem_err = 1'b1;
        #1;
        chk("t5_rst_req", 64'(emem_req), 64'd0);
        chk("t5_rst_addr", 64'(emem_addr), 64'd0);
        chk("t5_rst_dgnt", 64'(dmem_gnt), 64'd0);
        chk("t5_rst_derr", 64'(dmem_err), 64'd0);
        tick();
        imem_req = 1'b0; dmem_req = 1'b0; emem_gnt = 1'b0;
        tick();
        g_resetn = 1'b1;
        #1;
        chk("t5_rel_derr", 64'(dmem_err), 64'd0);
        chk("t5_rel_ierr", 64'(imem_err), 64'd0);
        tick();
        dmem_req = 1'b1; emem_gnt = 1'b1;
        #1;
        chk("t5_post_derr", 64'(dmem_err), 64'd0);
        chk("t5_post_dgnt", 64'(dmem_gnt), 64'd1);
        tick();
        dmem_req = 1'b0; emem_gnt = 1'b0; emem_err = 1'b0;
        tick();

        // Alternating back-to-back traffic; error pulses follow the previous owner
        emem_gnt = 1'b1; emem_err = 1'b1;
        for (int k = 0; k < 7; k++) begin
            imem_req = (k < 6) && (k % 2 == 0);
            dmem_req = (k < 6) && (k % 2 == 1);
            #1;
            if (k < 6) begin
                chk($sformatf("t6_req%0d", k), 64'(emem_req), 64'd1);
                chk($sformatf("t6_ignt%0d", k), 64'(imem_gnt), 64'(k % 2 == 0));
                chk($sformatf("t6_dgnt%0d", k), 64'(dmem_gnt), 64'(k % 2 == 1));
            end
            chk($sformatf("t6_ierr%0d", k), 64'(imem_err), 64'((k > 0) && ((k - 1) % 2 == 0)));
            chk($sformatf("t6_derr%0d", k), 64'(dmem_err), 64'((k > 0) && ((k - 1) % 2 == 1)));
            tick();
        end
        emem_gnt = 1'b0; emem_err = 1'b0;
        #1;
        chk("t6_tail_ierr", 64'(imem_err), 64'd0);
        chk("t6_tail_derr", 64'(dmem_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
